// File: rtl/riscv_pkg.sv
// ============================================================================
// Module : riscv_pkg
// Brief  : Shared core types and widths for the write-back path.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package riscv_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;
    localparam int NREGS  = 1 << REG_AW;

    typedef enum logic [0:0] {
        LSU_PRI = 1'b0,
        ALU_PRI = 1'b1
    } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/wb_scoreboard.sv
// ============================================================================
// Module : wb_scoreboard
// Brief  : Pending-write busy bits; issue sets, commit clears, set wins.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_scoreboard
    import riscv_pkg::REG_AW;
    import riscv_pkg::NREGS;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              set_valid,
    input  logic [REG_AW-1:0] set_rd,
    input  logic              clr_valid,
    input  logic [REG_AW-1:0] clr_rd,
    output logic [NREGS-1:0]  busy
);

    logic [NREGS-1:0] set_mask;
    logic [NREGS-1:0] clr_mask;
    logic [NREGS-1:0] busy_next;

    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (set_valid) set_mask[set_rd] = 1'b1;
        if (clr_valid) clr_mask[clr_rd] = 1'b1;
        // Set applied after clear so a same-cycle reissue keeps the bit.
        busy_next    = (busy & ~clr_mask) | set_mask;
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) busy <= '0;
        else     busy <= busy_next;
    end

endmodule

`default_nettype wire

// File: rtl/reg_wb_arbiter.sv
// ============================================================================
// Module : reg_wb_arbiter
// Brief  : ALU/LSU write-back arbiter with starvation guard and scoreboard.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_wb_arbiter
    import riscv_pkg::REG_AW;
    import riscv_pkg::NREGS;
    import riscv_pkg::arb_state_t;
    import riscv_pkg::LSU_PRI;
    import riscv_pkg::ALU_PRI;
#(
    parameter int XLEN         = riscv_pkg::XLEN,
    parameter int STARVE_LIMIT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alu_valid,
    input  logic [REG_AW-1:0] alu_rd,
    input  logic [XLEN-1:0]   alu_data,
    output logic              alu_ready,
    input  logic              lsu_valid,
    input  logic [REG_AW-1:0] lsu_rd,
    input  logic [XLEN-1:0]   lsu_data,
    output logic              lsu_ready,
    input  logic              issue_valid,
    input  logic [REG_AW-1:0] issue_rd,
    output logic [NREGS-1:0]  busy,
    output logic              reg_write,
    output logic [REG_AW-1:0] rd,
    output logic [XLEN-1:0]   write_data
);

    arb_state_t        state, state_next;
    logic [1:0]        starve, starve_next;
    logic              accept;
    logic [REG_AW-1:0] sel_rd;
    logic [XLEN-1:0]   sel_data;

    always_comb begin
        state_next = state;
        alu_ready  = 1'b0;
        lsu_ready  = 1'b0;
        if (!rst) begin
            alu_ready = alu_valid && (!lsu_valid || state == ALU_PRI);
            lsu_ready = lsu_valid && (!alu_valid || state == LSU_PRI);
        end

        starve_next = 2'd0;
        if (alu_valid && !alu_ready)
            starve_next = (starve == 2'd3) ? starve : starve + 2'd1;

        if (state == ALU_PRI) begin
            if (alu_ready) state_next = LSU_PRI;
        end else if (int'(starve_next) >= STARVE_LIMIT) begin
            state_next = ALU_PRI;
        end

        accept   = alu_ready || lsu_ready;
        sel_rd   = alu_ready ? alu_rd   : lsu_rd;
        sel_data = alu_ready ? alu_data : lsu_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= LSU_PRI;
            starve     <= 2'd0;
            reg_write  <= 1'b0;
            rd         <= '0;
            write_data <= '0;
        end else begin
            state     <= state_next;
            starve    <= starve_next;
            // x0 writes are acknowledged but never committed.
            reg_write <= accept && (sel_rd != '0);
            if (accept) begin
                rd         <= sel_rd;
                write_data <= sel_data;
            end
        end
    end

    wb_scoreboard u_scoreboard (
        .clk       (clk),
        .rst       (rst),
        .set_valid (issue_valid),
        .set_rd    (issue_rd),
        .clr_valid (reg_write),
        .clr_rd    (rd),
        .busy      (busy)
    );

endmodule

`default_nettype wire

// File: tb/tb_reg_wb_arbiter.sv
// ============================================================================
// Module : tb_reg_wb_arbiter
// Brief  : Directed and random checks of reg_wb_arbiter against a reference model.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_reg_wb_arbiter;

    localparam int XLEN  = 32;
    localparam int LIMIT = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            alu_valid = 1'b0, lsu_valid = 1'b0, issue_valid = 1'b0;
    logic [4:0]      alu_rd = '0, lsu_rd = '0, issue_rd = '0;
    logic [XLEN-1:0] alu_data = '0, lsu_data = '0;
    logic            alu_ready, lsu_ready, reg_write;
    logic [31:0]     busy;
    logic [4:0]      rd;
    logic [XLEN-1:0] write_data;

    int vectors = 0;
    int miscompares = 0;

    // Reference state: priority as a "forced ALU" flag, busy as a plain bit vector.
    bit              m_alu_forced;
    int              m_losses;
    bit [31:0]       m_busy;
    bit              m_rw;
    bit [4:0]        m_rd;
    bit [XLEN-1:0]   m_data;
    bit              m_gnt_alu, m_gnt_lsu;

    reg_wb_arbiter #(.XLEN(XLEN), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
        .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .busy(busy),
        .reg_write(reg_write), .rd(rd), .write_data(write_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_alu_forced = 1'b0;
        m_losses     = 0;
        m_busy       = '0;
        m_rw         = 1'b0;
        m_rd         = '0;
        m_data       = '0;
    endtask

    function automatic void model_grant();
        m_gnt_alu = alu_valid && (!lsu_valid || m_alu_forced);
        m_gnt_lsu = lsu_valid && !m_gnt_alu;
    endfunction

    function automatic void model_edge();
        bit [4:0] wrd;
        bit [31:0] b;
        b = m_busy;
        if (m_rw)        b[m_rd]     = 1'b0;
        if (issue_valid) b[issue_rd] = 1'b1;
        b[0] = 1'b0;
        m_busy = b;

        if (alu_valid && !m_gnt_alu) m_losses = (m_losses < 3) ? m_losses + 1 : 3;
        else                         m_losses = 0;
        if (m_alu_forced) begin
            if (m_gnt_alu) m_alu_forced = 1'b0;
        end else if (m_losses >= LIMIT) begin
            m_alu_forced = 1'b1;
        end

        wrd  = m_gnt_alu ? alu_rd : lsu_rd;
        m_rw = (m_gnt_alu || m_gnt_lsu) && (wrd != 0);
        if (m_gnt_alu || m_gnt_lsu) begin
            m_rd   = wrd;
            m_data = m_gnt_alu ? alu_data : lsu_data;
        end
    endfunction

    task automatic check_outputs(input string tag);
        check({tag, ".reg_write"}, 64'(reg_write), 64'(m_rw));
        check({tag, ".busy"}, 64'(busy), 64'(m_busy));
        if (m_rw) begin
            check({tag, ".rd"}, 64'(rd), 64'(m_rd));
            check({tag, ".data"}, 64'(write_data), 64'(m_data));
        end
    endtask

    // One clock: drive at posedge+1, check readies at posedge+4, outputs at next posedge+1.
    task automatic cycle(input string tag,
                         input bit av, input bit [4:0] ard, input bit [XLEN-1:0] ad,
                         input bit lv, input bit [4:0] lrd, input bit [XLEN-1:0] ld,
                         input bit iv, input bit [4:0] ird);
        alu_valid = av; alu_rd = ard; alu_data = ad;
        lsu_valid = lv; lsu_rd = lrd; lsu_data = ld;
        issue_valid = iv; issue_rd = ird;
        #3;
        model_grant();
        check({tag, ".alu_ready"}, 64'(alu_ready), 64'(m_gnt_alu));
        check({tag, ".lsu_ready"}, 64'(lsu_ready), 64'(m_gnt_lsu));
        @(posedge clk);
        #1;
        model_edge();
        check_outputs(tag);
    endtask

    task automatic idle(input string tag);
        cycle(tag, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    bit [5:0] gnt_hist;

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset.busy", 64'(busy), 64'd0);
        check("reset.reg_write", 64'(reg_write), 64'd0);
        check("reset.rd", 64'(rd), 64'd0);
        check("reset.data", 64'(write_data), 64'd0);
        check("reset.ready", 64'({alu_ready, lsu_ready}), 64'd0);
        rst = 1'b0;

        // ALU-only write
        cycle("alu_only", 1, 5'd5, 32'h11, 0, 0, 0, 0, 0);
        check("alu_only.rd_const", 64'(rd), 64'd5);
        check("alu_only.data_const", 64'(write_data), 64'h11);
        idle("idle0");

        // Both valid continuously: L, L, A, L, L, A
        for (int i = 0; i < 6; i++) begin
            cycle("starve", 1, 5'd1, 32'(100 + i), 1, 5'd2, 32'(200 + i), 0, 0);
            gnt_hist[i] = (rd == 5'd1);
            check("starve.rw_const", 64'(reg_write), 64'd1);
        end
        check("starve.pattern", 64'(gnt_hist), 64'(6'b100100));
        idle("idle1");

        // Scoreboard lifetime of r7
        cycle("sb7.issue", 0, 0, 0, 0, 0, 0, 1, 5'd7);
        idle("sb7.w1");
        check("sb7.busy_set", 64'(busy[7]), 64'd1);
        idle("sb7.w2");
        cycle("sb7.write", 0, 0, 0, 1, 5'd7, 32'h77, 0, 0);
        check("sb7.busy_during_rw", 64'(busy[7]), 64'd1);
        idle("sb7.clear");
        check("sb7.busy_cleared", 64'(busy[7]), 64'd0);

        // Same-cycle commit and reissue of r9
        cycle("sb9.issue", 0, 0, 0, 0, 0, 0, 1, 5'd9);
        cycle("sb9.write", 0, 0, 0, 1, 5'd9, 32'h99, 0, 0);
        cycle("sb9.both", 0, 0, 0, 0, 0, 0, 1, 5'd9);
        check("sb9.set_wins", 64'(busy[9]), 64'd1);
        cycle("sb9.write2", 0, 0, 0, 1, 5'd9, 32'h9a, 0, 0);
        idle("sb9.clear");

        // x0 write is acknowledged only
        cycle("x0", 1, 5'd0, 32'hFF, 0, 0, 0, 1, 5'd0);
        check("x0.rw_const", 64'(reg_write), 64'd0);
        check("x0.busy_const", 64'(busy), 64'd0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            cycle("rand", bit'($urandom_range(0, 1)), 5'($urandom), $urandom,
                  bit'($urandom_range(0, 1)), 5'($urandom), $urandom,
                  bit'($urandom_range(0, 3) == 0), 5'($urandom));
        end

        // Mid-stream reset with busy = 0x0F00
        idle("pre_rst");
        m_busy = '0;
        rst = 1'b1; #1; rst = 1'b0;
        for (int r = 8; r < 12; r++) cycle("rst.issue", 0, 0, 0, 0, 0, 0, 1, 5'(r));
        check("rst.busy_pre", 64'(busy), 64'h0F00);
        alu_valid = 1; alu_rd = 5'd3; alu_data = 32'h33;
        lsu_valid = 1; lsu_rd = 5'd4; lsu_data = 32'h44;
        issue_valid = 0;
        #2;
        rst = 1'b1;
        #1;
        check("rst.busy", 64'(busy), 64'd0);
        check("rst.reg_write", 64'(reg_write), 64'd0);
        check("rst.ready", 64'({alu_ready, lsu_ready}), 64'd0);
        @(posedge clk);
        #1;
        check("rst.hold_rw", 64'(reg_write), 64'd0);
        model_reset();
        rst = 1'b0;
        cycle("rst.first", 1, 5'd3, 32'h33, 1, 5'd4, 32'h44, 0, 0);
        check("rst.lsu_wins", 64'(rd), 64'd4);
        idle("done");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule

`default_nettype wire

// File: doc/reg_wb_arbiter.md
REG_WB_ARBITER -- requirements
Module: reg_wb_arbiter

Interface
REQ-001 Parameter XLEN, default 32: data width of write-back values.
REQ-002 Parameter STARVE_LIMIT, default 2: consecutive ALU losses before the ALU gets forced priority.
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset; asynchronous, active-high.
REQ-005 alu_valid  input  1  ALU write-back request.
REQ-006 alu_rd  input  5  ALU destination register.
REQ-007 alu_data  input  XLEN  ALU result.
REQ-008 alu_ready  output  1  ALU request accepted this cycle (combinational).
REQ-009 lsu_valid  input  1  load write-back request.
REQ-010 lsu_rd  input  5  load destination register.
REQ-011 lsu_data  input  XLEN  load result.
REQ-012 lsu_ready  output  1  LSU request accepted this cycle (combinational).
REQ-013 issue_valid  input  1  an instruction writing issue_rd has been issued.
REQ-014 issue_rd  input  5  destination register of the issued instruction.
REQ-015 busy  output  32  pending-write scoreboard, one bit per architectural register.
REQ-016 reg_write  output  1  register-file write enable (registered).
REQ-017 rd  output  5  register-file write address (registered).
REQ-018 write_data  output  XLEN  register-file write data (registered).

Function
REQ-019 The block SHALL accept at most one request per cycle; a request is accepted when valid and ready are both high.
REQ-020 Arbitration state SHALL be LSU_PRI or ALU_PRI; in LSU_PRI, LSU wins when both sources are valid; in ALU_PRI, ALU wins.
REQ-021 A 2-bit starve counter SHALL increment when alu_valid is high and the ALU loses, and clear when the ALU is accepted or alu_valid is low.
REQ-022 The state SHALL move LSU_PRI->ALU_PRI when the counter reaches STARVE_LIMIT; it SHALL return ALU_PRI->LSU_PRI after one ALU acceptance.
REQ-023 With a single valid source, that source SHALL be accepted regardless of state.
REQ-024 An accepted request SHALL appear on rd/write_data with reg_write=1 exactly one cycle later; reg_write SHALL be 0 in any cycle following no acceptance.
REQ-025 An accepted request with rd=0 SHALL be acknowledged (ready=1) but SHALL produce reg_write=0 and SHALL NOT alter busy.
REQ-026 issue_valid with issue_rd!=0 SHALL set busy[issue_rd] on the next edge.
REQ-027 A committed write (reg_write=1) SHALL clear busy[rd] on the next edge.
REQ-028 When a set and a clear target the same register in the same cycle, the set SHALL win.
REQ-029 busy[0] SHALL be constantly 0.
REQ-030 Write-back to a register whose busy bit is 0 SHALL still be performed, with busy unchanged.

Reset
REQ-031 While rst is high: reg_write=0, rd=0, write_data=0, busy=0, state=LSU_PRI, starve counter=0.
REQ-032 alu_ready and lsu_ready SHALL be 0 while rst is high; a request presented during reset SHALL be dropped, not buffered.
REQ-033 Deassertion of rst SHALL allow acceptance in the first following cycle.

Structure
REQ-034 XLEN, the register address width (5), and the arbitration state enum SHALL live in the shared core package riscv_pkg.
REQ-035 Scoreboard set/clear logic SHALL be a sub-module named wb_scoreboard; arbitration and output registers stay in reg_wb_arbiter.

Verification
REQ-036 ALU only, alu_rd=5, alu_data=0x11 -> alu_ready=1; next cycle reg_write=1, rd=5, write_data=0x11.
REQ-037 Both valid every cycle, STARVE_LIMIT=2 -> grants LSU, LSU, ALU, LSU, LSU, ALU; reg_write=1 every cycle.
REQ-038 issue_valid with issue_rd=7, then an LSU write to rd=7 three cycles later -> busy[7]=1 from the next cycle until the cycle after reg_write, then 0.
REQ-039 Same cycle: reg_write commits rd=9 and issue_valid with issue_rd=9 -> busy[9] remains 1.
REQ-040 ALU write to rd=0 with data 0xFF -> alu_ready=1, reg_write stays 0, busy stays 0.
REQ-041 rst asserted mid-stream with busy=0x0000_0F00 and both sources valid -> busy=0, reg_write=0, ready=0 immediately; LSU wins the first cycle after release.
